serial_audio_format_controller: RTL and testbench

- Sequences and configures one serial_audio_decoder: drives its is_i2s and lrclk_polarity inputs and watches its error flag and channel order.
- Auto mode: scans the four format candidates until the decoder produces a clean, alternating L/R stream, then locks.
- Manual mode: applies host-supplied settings directly.
- Sits between the decoder output and the downstream audio consumer, gating the stream until lock. Runs in the decoder's sclk domain.

---
 rtl/serial_audio_format_controller.sv | 141 ++++++++++++++
 tb/tb_serial_audio_format_controller.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_audio_format_controller.sv
// Format scanner and stream gate in front of one serial audio decoder.
// Auto mode hunts the four {is_i2s, polarity} candidates; manual mode applies host settings.
module serial_audio_format_controller #(
    parameter int SETTLE_CYCLES = 128,
    parameter int LOCK_WORDS    = 4,
    parameter int UNLOCK_ERRORS = 2
) (
    input  logic        sclk,
    input  logic        reset,
    input  logic        cfg_auto,
    input  logic        cfg_is_i2s,
    input  logic        cfg_lrclk_polarity,
    output logic        dec_is_i2s,
    output logic        dec_lrclk_polarity,
    input  logic        dec_is_error,
    input  logic        dec_valid,
    output logic        dec_ready,
    input  logic        dec_is_left,
    input  logic [31:0] dec_audio,
    output logic        o_valid,
    input  logic        o_ready,
    output logic        o_is_left,
    output logic [31:0] o_audio,
    output logic        locked,
    output logic [1:0]  format,
    output logic [7:0]  scan_count
);

    typedef enum logic [1:0] {SETTLE, HUNT, LOCKED, MANUAL} state_t;

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [7:0]  LOCK_CNT    = 8'(LOCK_WORDS);
    localparam logic [3:0]  UNLOCK_CNT  = 4'(UNLOCK_ERRORS);

    state_t      state, state_nx;
    logic [1:0]  fmt, fmt_nx;
    logic [15:0] settle_cnt, settle_nx;
    logic [7:0]  good, good_nx;
    logic [3:0]  err, err_nx;
    logic        exp_left, exp_left_nx;
    logic        err_q;
    logic [7:0]  scans, scans_nx;
    logic        xfer, err_ev, mismatch;

    assign locked             = (state == LOCKED) || (state == MANUAL);
    assign dec_ready          = locked ? o_ready : 1'b1;
    assign o_valid            = locked & dec_valid;
    assign o_is_left          = dec_is_left;
    assign o_audio            = dec_audio;
    assign dec_is_i2s         = fmt[1];
    assign dec_lrclk_polarity = fmt[0];
    assign format             = fmt;
    assign scan_count         = scans;

    assign xfer     = dec_valid & dec_ready;
    assign err_ev   = dec_is_error & ~err_q;
    assign mismatch = xfer & (dec_is_left != exp_left);

    always_comb begin
        state_nx    = state;
        fmt_nx      = fmt;
        settle_nx   = settle_cnt;
        good_nx     = good;
        err_nx      = err;
        exp_left_nx = exp_left;
        scans_nx    = scans;
        if (!cfg_auto) begin
            state_nx = MANUAL;
            fmt_nx   = {cfg_is_i2s, cfg_lrclk_polarity};
        end else begin
            unique case (state)
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state_nx    = HUNT;
                        good_nx     = '0;
                        exp_left_nx = 1'b1;
                    end else begin
                        settle_nx = settle_cnt + 16'd1;
                    end
                end
                HUNT: begin
                    // an error edge outranks a word arriving in the same cycle
                    if (err_ev || mismatch) begin
                        state_nx  = SETTLE;
                        settle_nx = '0;
                        fmt_nx    = fmt + 2'd1;
                        if (scans != 8'hFF)
                            scans_nx = scans + 8'd1;
                    end else if (xfer) begin
                        good_nx     = good + 8'd1;
                        exp_left_nx = ~exp_left;
                        if (good + 8'd1 == LOCK_CNT) begin
                            state_nx = LOCKED;
                            err_nx   = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (xfer)
                        exp_left_nx = ~dec_is_left;
                    if (err_ev || mismatch) begin
                        err_nx = err + 4'd1;
                        if (err + 4'd1 == UNLOCK_CNT) begin
                            state_nx  = SETTLE;
                            settle_nx = '0;
                        end
                    end
                end
                MANUAL: begin
                    state_nx  = SETTLE;
                    settle_nx = '0;
                    fmt_nx    = 2'd0;
                end
                default: state_nx = SETTLE;
            endcase
        end
    end

    always_ff @(posedge sclk) begin
        if (reset) begin
            state      <= SETTLE;
            fmt        <= '0;
            settle_cnt <= '0;
            good       <= '0;
            err        <= '0;
            exp_left   <= 1'b1;
            err_q      <= 1'b0;
            scans      <= '0;
        end else begin
            state      <= state_nx;
            fmt        <= fmt_nx;
            settle_cnt <= settle_nx;
            good       <= good_nx;
            err        <= err_nx;
            exp_left   <= exp_left_nx;
            err_q      <= dec_is_error;
            scans      <= scans_nx;
        end
    end

endmodule

// File: tb/tb_serial_audio_format_controller.sv
// Scenario bench for serial_audio_format_controller.
module tb_serial_audio_format_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_auto, cfg_is_i2s, cfg_lrclk_polarity;
    logic        dec_is_i2s, dec_lrclk_polarity;
    logic        dec_is_error, dec_valid, dec_ready, dec_is_left;
    logic [31:0] dec_audio;
    logic        o_valid, o_ready, o_is_left;
    logic [31:0] o_audio;
    logic        locked;
    logic [1:0]  format;
    logic [7:0]  scan_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [32:0] sb[$];

    serial_audio_format_controller dut (
        .sclk(clk), .reset(reset),
        .cfg_auto(cfg_auto), .cfg_is_i2s(cfg_is_i2s),
        .cfg_lrclk_polarity(cfg_lrclk_polarity),
        .dec_is_i2s(dec_is_i2s), .dec_lrclk_polarity(dec_lrclk_polarity),
        .dec_is_error(dec_is_error), .dec_valid(dec_valid),
        .dec_ready(dec_ready), .dec_is_left(dec_is_left),
        .dec_audio(dec_audio), .o_valid(o_valid), .o_ready(o_ready),
        .o_is_left(o_is_left), .o_audio(o_audio), .locked(locked),
        .format(format), .scan_count(scan_count)
    );

    always #5 clk = ~clk;

    // scoreboard: every downstream handshake must match the oldest pushed word
    always @(negedge clk) begin
        if (o_valid && o_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output left=%b audio=%h required=none",
                         o_is_left, o_audio);
            end else begin
                logic [32:0] e;
                e = sb.pop_front();
                if ({o_is_left, o_audio} !== e) begin
                    n_fail++;
                    $display("FAIL output_word got=%h required=%h",
                             {o_is_left, o_audio}, e);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cfg_auto = 1; cfg_is_i2s = 0; cfg_lrclk_polarity = 0;
        dec_is_error = 0; dec_valid = 0; dec_is_left = 0;
        dec_audio = '0; o_ready = 1;
        reset = 1;
        tick(2);
        reset = 0;
    endtask

    task automatic send_word(input logic left, input logic [31:0] d,
                             input logic deliver);
        dec_valid = 1; dec_is_left = left; dec_audio = d;
        if (deliver) sb.push_back({left, d});
        tick(1);
        dec_valid = 0;
    endtask

    task automatic err_pulse();
        dec_is_error = 1;
        tick(1);
        dec_is_error = 0;
    endtask

    task automatic lock_lrlr();
        send_word(1, 32'h1000_0001, 0);
        send_word(0, 32'h2000_0002, 0);
        send_word(1, 32'h3000_0003, 0);
        send_word(0, 32'h4000_0004, 0);
    endtask

    task automatic test_reset();
        reset = 1;
        do_reset();
        n_checks++;
        if ({dec_is_i2s, dec_lrclk_polarity, format, locked, scan_count}
            !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_values got=%b required=0",
                     {dec_is_i2s, dec_lrclk_polarity, format, locked, scan_count});
        end
        n_checks++;
        if (dec_ready !== 1'b1 || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_datapath ready=%b valid=%b required=1,0",
                     dec_ready, o_valid);
        end
    endtask

    task automatic test_lock_left_justified();
        do_reset();
        tick(127);
        n_checks++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL settle_unlocked got=%b required=0", locked);
        end
        tick(3);
        send_word(1, 32'h1111_0000, 0);
        send_word(0, 32'h2222_0000, 0);
        send_word(1, 32'h3333_0000, 0);
        n_checks++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL early_lock got=%b required=0", locked);
        end
        send_word(0, 32'h4444_0000, 0);
        n_checks++;
        if ({locked, format, scan_count} !== {1'b1, 2'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL lock_lj got=%b/%0d/%0d required=1/0/0",
                     locked, format, scan_count);
        end
        send_word(1, 32'h2EEF_0000, 1);
        send_word(0, 32'h0BAD_CAFE, 1);
    endtask

    task automatic test_scan();
        do_reset();
        tick(130);
        err_pulse();
        n_checks++;
        if ({format, scan_count} !== {2'd1, 8'd1}) begin
            n_fail++;
            $display("FAIL scan_step1 got=%0d/%0d required=1/1",
                     format, scan_count);
        end
        tick(130);
        err_pulse();
        tick(130);
        lock_lrlr();
        n_checks++;
        if ({locked, format, scan_count, dec_is_i2s, dec_lrclk_polarity}
            !== {1'b1, 2'b10, 8'd2, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL scan_lock got=%b/%b/%0d/%b%b required=1/10/2/10",
                     locked, format, scan_count, dec_is_i2s, dec_lrclk_polarity);
        end
    endtask

    task automatic test_channel_fault();
        do_reset();
        tick(130);
        send_word(1, 32'hA, 0);
        send_word(1, 32'hB, 0);
        n_checks++;
        if ({locked, format, scan_count} !== {1'b0, 2'd1, 8'd1}) begin
            n_fail++;
            $display("FAIL chan_fault got=%b/%0d/%0d required=0/1/1",
                     locked, format, scan_count);
        end
        tick(130);
        dec_is_error = 1;
        send_word(1, 32'hC, 0);
        dec_is_error = 0;
        n_checks++;
        if ({format, scan_count} !== {2'd2, 8'd2}) begin
            n_fail++;
            $display("FAIL err_beats_word got=%0d/%0d required=2/2",
                     format, scan_count);
        end
    endtask

    task automatic test_unlock_retry();
        do_reset();
        tick(130);
        lock_lrlr();
        dec_is_error = 1;
        tick(10);
        dec_is_error = 0;
        tick(3);
        n_checks++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL held_error_once got=%b required=1", locked);
        end
        dec_is_error = 1;
        send_word(1, 32'h5A5A_0001, 1);
        dec_is_error = 0;
        n_checks++;
        if ({locked, format, scan_count} !== {1'b0, 2'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL unlock_retry got=%b/%0d/%0d required=0/0/0",
                     locked, format, scan_count);
        end
        tick(130);
        lock_lrlr();
        n_checks++;
        if ({locked, format, scan_count} !== {1'b1, 2'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL relock got=%b/%0d/%0d required=1/0/0",
                     locked, format, scan_count);
        end
    endtask

    task automatic test_manual();
        cfg_auto = 0; cfg_is_i2s = 1; cfg_lrclk_polarity = 1;
        tick(1);
        n_checks++;
        if ({format, locked, dec_is_i2s, dec_lrclk_polarity}
            !== {2'd3, 1'b1, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL manual_cfg got=%0d/%b required=3/1", format, locked);
        end
        o_ready = 0; dec_valid = 1; dec_is_left = 0; dec_audio = 32'hCAFE_F00D;
        @(negedge clk);
        n_checks++;
        if ({dec_ready, o_valid, o_audio} !== {1'b0, 1'b1, 32'hCAFE_F00D}) begin
            n_fail++;
            $display("FAIL manual_bp got=%b/%b/%h required=0/1/cafef00d",
                     dec_ready, o_valid, o_audio);
        end
        tick(3);
        n_checks++;
        if (o_audio !== 32'hCAFE_F00D || dec_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL manual_hold got=%h/%b required=cafef00d/0",
                     o_audio, dec_ready);
        end
        o_ready = 1;
        sb.push_back({1'b0, 32'hCAFE_F00D});
        tick(1);
        dec_valid = 0;
        cfg_auto = 1;
        tick(1);
        n_checks++;
        if ({format, locked, scan_count} !== {2'd0, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL manual_exit got=%0d/%b/%0d required=0/0/0",
                     format, locked, scan_count);
        end
        cfg_is_i2s = 0; cfg_lrclk_polarity = 0;
    endtask

    task automatic test_reset_mid_hunt();
        do_reset();
        tick(130);
        err_pulse();
        tick(130);
        send_word(1, 32'h1, 0);
        send_word(0, 32'h2, 0);
        send_word(1, 32'h3, 0);
        reset = 1;
        send_word(0, 32'h4, 0);
        n_checks++;
        if ({dec_is_i2s, dec_lrclk_polarity, format, locked, scan_count}
            !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_mid_hunt got=%b required=0",
                     {dec_is_i2s, dec_lrclk_polarity, format, locked, scan_count});
        end
        reset = 0;
        tick(140);
        n_checks++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL no_lock_after_reset got=%b required=0", locked);
        end
    endtask

    initial begin
        test_reset();
        test_lock_left_justified();
        test_scan();
        test_channel_fault();
        test_unlock_retry();
        test_manual();
        test_reset_mid_hunt();
        tick(2);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL words_missing got=%0d required=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
